mux8way_rr_collector: RTL
=========================

// Module: mux8way_rr_collector
// PURPOSE
//  Gathers words from 8 source channels onto one output stream: the gather-side
//  counterpart of the 1-to-8 demultiplexer tree. Round-robin arbitration picks one
//  requesting source per transfer.
//  The output is registered, with a valid/ready handshake and a 3-bit source tag
//  (out_sel) in the same encoding as the demux select (channel a=0 ... h=7).
//  Placed in front of any single consumer shared by 8 producers.
// PARAMETERS
//  WIDTH  16  data width of each channel and of the output
// PORTS
//  clk        in   1          rising-edge clock, single clock domain
//  reset      in   1          synchronous reset, active-high
//  in_valid   in   8          bit k: channel k offers a word
//  in_data    in   8*WIDTH    channel k data at in_data[k*WIDTH +: WIDTH]
//  in_ready   out  8          bit k: channel k word is accepted this cycle
//  out_valid  out  1          out_data/out_sel hold a valid word
//  out_data   out  WIDTH      collected word
//  out_sel    out  3          index of the source channel of out_data
//  out_ready  in   1          consumer accepts the word this cycle
// BEHAVIOUR
//  - Reset (sync, high): out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0.
//    in_ready=8'h00 while reset is high, regardless of the other inputs.
//  - Two states:
//    EMPTY = output register free (out_valid=0).
//    FULL  = output register holds a word (out_valid=1).
//  - load = !out_valid | out_ready   (register free now or being drained).
//  - Grant: when load=1 and in_valid!=0, grant the first channel k with
//    in_valid[k]=1, searching ptr, ptr+1, ... mod 8.
//  - in_ready = onehot(k) when granted, else 8'h00.
//    in_ready is combinational from in_valid, ptr, out_valid and out_ready.
//  - A transfer on channel k is in_valid[k] & in_ready[k].
//    On the next edge: out_data<=word, out_sel<=k, out_valid<=1, ptr<=(k+1) mod 8.
//    ptr wraps from 7 to 0.
//  - Drain with no grant: out_ready=1 and in_valid=0 give out_valid<=0 on the next edge.
//    out_data and out_sel keep their last values.
//  - Stall: out_valid=1 and out_ready=0 give in_ready=0.
//    out_data and out_sel stay stable until accepted. ptr is unchanged.
//  - Simultaneous drain and grant in one cycle: the register reloads with the new word.
//    This sustains 1 word/cycle.
//  - Latency: 1 cycle from the input transfer to out_valid.
//  - A source may drop in_valid before it is granted. No word is taken and no state changes.
//  - Reset mid-transfer: the held word is discarded and the pending grant is not performed.
//  - Fairness: with all 8 sources valid, each source is granted once in every 8 grants.
// TESTING
//  - Reset: reset=1 for 2 cycles, in_valid=8'hFF
//    -> in_ready=0, out_valid=0, out_sel=0, out_data=0.
//  - Single source: in_valid=8'h08, ch3 data=16'hBEEF, out_ready=1
//    -> in_ready=8'h08; next cycle out_valid=1, out_data=BEEF, out_sel=3.
//  - Round robin: in_valid=8'hFF held, out_ready=1
//    -> out_sel sequence 0,1,...,7,0; in_ready walks 01,02,...,80,01.
//  - Stall: out_valid=1 with out_sel=5 and out_ready=0 for 3 cycles
//    -> out_data/out_sel unchanged, in_ready=0; then out_ready=1 -> next grant is ch6 or later.
//  - Wrap: grant ch7, then in_valid=8'h81 -> ch0 granted next, then ch7.
//  - Reset while FULL (out_sel=2, out_ready=0) -> next cycle out_valid=0; first grant after
//    reset with in_valid=8'h06 goes to ch1.

Source files
------------

// File: rtl/mux8way_rr_collector_if.sv
// Gather bus for the 8-to-1 round-robin collector.
// Per-channel valid/ready/data in; one tagged word out.
interface mux8way_rr_collector_if #(
  parameter int WIDTH = 16
);
  logic [7:0]         in_valid;
  logic [8*WIDTH-1:0] in_data;
  logic [7:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [2:0]         out_sel;
  logic               out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/mux8way_rr_collector.sv
// 8-to-1 round-robin collector with a registered, tagged output.
// Reloads on the drain cycle, so it sustains one word per cycle.
module mux8way_rr_collector #(
  parameter int WIDTH = 16
) (
  input logic                   clk,
  input logic                   reset,
  mux8way_rr_collector_if.slave bus
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       ptr_q, ptr_d;

  logic       load;
  logic       grant;
  logic [2:0] gidx;
  logic [2:0] idx;
  logic [7:0] gnt;

  // Walk from farthest to nearest offset so the
  // nearest requester at or after ptr wins.
  always_comb begin
    load  = (state_q == EMPTY) | bus.out_ready;
    grant = 1'b0;
    gidx  = ptr_q;
    idx   = '0;
    for (int i = 7; i >= 0; i--) begin
      idx = ptr_q + 3'(i);
      if (bus.in_valid[idx]) begin
        grant = 1'b1;
        gidx  = idx;
      end
    end
    gnt = '0;
    if (load && grant && !reset) begin
      gnt = 8'b1 << gidx;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (load) begin
      if (grant) begin
        state_d = FULL;
        data_d  = bus.in_data[gidx*WIDTH +: WIDTH];
        sel_d   = gidx;
        ptr_d   = gidx + 3'd1;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.in_ready  = gnt;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;

endmodule
